// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction memory responder.
package imem_pkg;

    localparam int INST_WIDTH = 32;
    localparam int ADDR_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, one asynchronous read port.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  logic [INST_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] ridx,
    output logic [INST_WIDTH-1:0]    rdata
);

    logic [INST_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder with backdoor preload.
// Optional macro IMEM_ADDR_CHECK_EN flags misaligned / out-of-range fetches via resp_err.
module imem_responder
    import imem_pkg::*;
#(
    parameter int                    DEPTH     = 1024,
    parameter int                    LATENCY   = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [INST_WIDTH-1:0]    resp_data,
    output logic                     resp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [INST_WIDTH-1:0]    ld_data
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              cnt;
    logic [IDX_W-1:0]        rd_idx;
    logic [INST_WIDTH-1:0]   rd_word;
    logic                    accept;
    logic                    addr_bad;
    logic [INST_WIDTH-1:0]   data_q;
    logic                    err_q;

    assign rd_idx = IDX_W'((req_addr - BASE_ADDR) >> 2);
    assign accept = (state == IDLE) && req_valid;

`ifdef IMEM_ADDR_CHECK_EN
    // A wrapped offset (addr below base) is huge, so one compare covers both bounds.
    assign addr_bad = (req_addr[1:0] != 2'b00) ||
                      ((req_addr - BASE_ADDR) >= ADDR_WIDTH'(4 * DEPTH));
`else
    assign addr_bad = 1'b0;
`endif

    imem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (ld_en && rst),
        .widx  (ld_idx),
        .wdata (ld_data),
        .ridx  (rd_idx),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid) state_next = (LATENCY == 1) ? RESP : WAIT;
            WAIT: if (cnt == 4'd1) state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
    end

    // Response word is captured at accept, so later preloads cannot disturb it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= 4'd0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            cnt    <= (LATENCY == 1) ? 4'd0 : 4'(LATENCY - 1);
            data_q <= addr_bad ? '0 : rd_word;
            err_q  <= addr_bad;
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign resp_data = data_q;
    assign resp_err  = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder (LATENCY=2 and LATENCY=1 instances).
module tb_imem_responder;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        resp_ready;
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;

    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_data;
    logic        req_ready1, resp_valid1, resp_err1;
    logic [31:0] resp_data1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(64'h8000_0000)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err), .ld_en(ld_en),
        .ld_idx(ld_idx), .ld_data(ld_data)
    );

    imem_responder #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(64'h8000_0000)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
        .req_addr(req_addr), .resp_valid(resp_valid1), .resp_ready(resp_ready),
        .resp_data(resp_data1), .resp_err(resp_err1), .ld_en(ld_en),
        .ld_idx(ld_idx), .ld_data(ld_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] d);
        ld_en = 1'b1; ld_idx = idx; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    // Full fetch with resp_ready=1; optionally a preload in the accept cycle.
    task automatic fetch(input logic [63:0] addr, input logic ld, input logic [9:0] li,
                         input logic [31:0] ld_d, input logic [31:0] exp_d, input logic exp_e);
        req_valid = 1'b1; req_addr = addr; resp_ready = 1'b1;
        ld_en = ld; ld_idx = li; ld_data = ld_d;
        step();
        req_valid = 1'b0; ld_en = 1'b0;
        check("l2_wait_valid", resp_valid, 0);
        check("l2_wait_ready", req_ready, 0);
        check("l1_valid", resp_valid1, 1);
        check("l1_data", resp_data1, exp_d);
        check("l1_err", resp_err1, exp_e);
        step();
        check("l2_valid", resp_valid, 1);
        check("l2_data", resp_data, exp_d);
        check("l2_err", resp_err, exp_e);
        check("l1_idle_ready", req_ready1, 1);
        step();
        check("l2_idle_ready", req_ready, 1);
        check("l2_idle_valid", resp_valid, 0);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
        ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        step();
        step();
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        rst = 1'b1;

        preload(10'd0, 32'h00100093);
        preload(10'd1, 32'h11111111);
        preload(10'd4, 32'h00000013);
        preload(10'd5, 32'h00000055);

        // Basic latency-2 fetch of word 0
        fetch(64'h8000_0000, 1'b0, 10'd0, 32'h0, 32'h00100093, 1'b0);

        // Backpressure: response held while resp_ready=0, new requests ignored
        req_valid = 1'b1; req_addr = 64'h8000_0004; resp_ready = 1'b0;
        step();
        req_addr = 64'h8000_0010;
        step();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", resp_valid, 1);
            check("hold_data", resp_data, 32'h11111111);
            check("hold_ready", req_ready, 0);
            check("hold_l1_data", resp_data1, 32'h11111111);
            if (i == 4) begin
                resp_ready = 1'b1;
                req_valid = 1'b0;
            end
            step();
        end
        check("hold_release_ready", req_ready, 1);
        check("hold_release_valid", resp_valid, 0);

        // Read-before-write on accept cycle, then the new word is visible
        fetch(64'h8000_0010, 1'b1, 10'd4, 32'hDEADBEEF, 32'h00000013, 1'b0);
        fetch(64'h8000_0010, 1'b0, 10'd0, 32'h0, 32'hDEADBEEF, 1'b0);

`ifdef IMEM_ADDR_CHECK_EN
        fetch(64'h8000_0002, 1'b0, 10'd0, 32'h0, 32'h0, 1'b1);
        fetch(64'h7FFF_FFFC, 1'b0, 10'd0, 32'h0, 32'h0, 1'b1);
        fetch(64'h8000_1000, 1'b0, 10'd0, 32'h0, 32'h0, 1'b1);
        fetch(64'h8000_0FFC, 1'b0, 10'd0, 32'h0, 32'h0, 1'b0);
`else
        fetch(64'h8000_1000, 1'b0, 10'd0, 32'h0, 32'h00100093, 1'b0);
        fetch(64'h8000_0002, 1'b0, 10'd0, 32'h0, 32'h00100093, 1'b0);
`endif

        // Reset mid-WAIT abandons the request; preload during reset is ignored
        req_valid = 1'b1; req_addr = 64'h8000_0014; resp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check("pre_rst_wait_valid", resp_valid, 0);
        rst = 1'b0; ld_en = 1'b1; ld_idx = 10'd5; ld_data = 32'h00000BAD;
        step();
        rst = 1'b1; ld_en = 1'b0;
        check("midrst_valid", resp_valid, 0);
        check("midrst_ready", req_ready, 1);
        check("midrst_data", resp_data, 0);
        check("midrst_l1_valid", resp_valid1, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("abandoned_no_resp", resp_valid, 0);
        end
        fetch(64'h8000_0014, 1'b0, 10'd0, 32'h0, 32'h00000055, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
